dtw_ref_arbiter: RTL and testbench

- Shares one reference-memory core (dtw_core_ref) between N_REQ DTW requesters.
- Round-robin arbitrates read requests, drives the core's read address and returns tagged read data after the fixed core read latency.
- Sequences the core's operating mode: DTW read service vs. reference reload. Drains in-flight reads before handing the core over to a load.

---
 rtl/dtw_ref_arb_pkg.sv | 15 +
 rtl/dtw_rr_picker.sv | 32 +++
 rtl/dtw_ref_arbiter.sv | 176 +++++++++++++++++
 tb/tb_dtw_ref_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtw_ref_arb_pkg.sv
// Shared encodings for the DTW reference-memory arbiter: FSM states and core operating modes.
package dtw_ref_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_LOAD  = 3'd3,
    ST_DONE  = 3'd4
  } arb_state_t;

  localparam logic MODE_DTW_READ = 1'b0;
  localparam logic MODE_LOAD_REF = 1'b1;

endpackage

// File: rtl/dtw_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N_REQ.
module dtw_rr_picker #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             any,
  output logic [PW-1:0]    idx,
  output logic [N_REQ-1:0] onehot
);

  // Scan from the farthest candidate back to ptr so the last hit is the nearest one.
  always_comb begin
    logic [PW-1:0] j;
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    j      = '0;
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = PW'((int'(ptr) + k) % N_REQ);
      if (req[j]) begin
        any       = 1'b1;
        idx       = j;
        onehot    = '0;
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dtw_ref_arbiter.sv
// Shares one reference-memory core between N_REQ DTW requesters: round-robin reads with tagged,
// fixed-latency responses, and sequencing of reference reloads after draining in-flight reads.
module dtw_ref_arbiter
  import dtw_ref_arb_pkg::*;
#(
  parameter int N_REQ            = 4,
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH       = 32,
  parameter int REFMEM_PTR_WIDTH = 20,
  parameter int RD_LATENCY       = 2,
  parameter int LOAD_TIMEOUT     = 16
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              enable_in,
  input  logic                              load_req_in,
  input  logic [ADDR_WIDTH-1:0]             ref_len_in,
  input  logic [N_REQ-1:0]                  req_valid_in,
  input  logic [N_REQ*REFMEM_PTR_WIDTH-1:0] req_addr_in,
  output logic [N_REQ-1:0]                  grant_out,
  output logic [N_REQ-1:0]                  rsp_valid_out,
  output logic [DATA_WIDTH-1:0]             rsp_data_out,
  output logic                              rsp_err_out,
  output logic                              load_ack_out,
  output logic                              load_fail_out,
  output logic                              core_rs_out,
  output logic                              core_op_mode_out,
  input  logic                              core_busy_in,
  output logic [REFMEM_PTR_WIDTH-1:0]       ref_addr_out,
  input  logic [DATA_WIDTH-1:0]             ref_data_in,
  output logic [2:0]                        state_out
);

  localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW   = $clog2(LOAD_TIMEOUT + 1);
  localparam int CW   = (ADDR_WIDTH > REFMEM_PTR_WIDTH) ? ADDR_WIDTH : REFMEM_PTR_WIDTH;
  localparam int LAST = RD_LATENCY - 1;

  arb_state_t                  state, state_nxt;
  logic [PW-1:0]               rr_ptr;
  logic [REFMEM_PTR_WIDTH-1:0] addr_q;
  logic [TW-1:0]               tmo_cnt;
  logic                        seen_busy;
  logic                        fail_q;

  logic [RD_LATENCY-1:0]       pipe_vld;
  logic [RD_LATENCY-1:0]       pipe_err;
  logic [PW-1:0]               pipe_id [RD_LATENCY];

  logic                        pick_any;
  logic [PW-1:0]               pick_idx;
  logic [N_REQ-1:0]            pick_onehot;
  logic [REFMEM_PTR_WIDTH-1:0] win_addr;
  logic                        win_err;
  logic                        do_grant;
  logic                        pipe_busy;
  logic                        load_ok;
  logic                        load_tmo;

  dtw_rr_picker #(.N_REQ(N_REQ), .PW(PW)) u_picker (
    .req    (req_valid_in),
    .ptr    (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign win_addr = req_addr_in[int'(pick_idx)*REFMEM_PTR_WIDTH +: REFMEM_PTR_WIDTH];
  assign win_err  = CW'(win_addr) >= CW'(ref_len_in);

  // The last stage may be issuing this cycle; only earlier stages keep the core occupied.
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < LAST; i++) pipe_busy = pipe_busy | pipe_vld[i];
  end

  assign load_ok  = seen_busy && !core_busy_in;
  assign load_tmo = !seen_busy && !core_busy_in && (tmo_cnt == TW'(LOAD_TIMEOUT - 1));

  always_comb begin
    state_nxt        = state;
    do_grant         = 1'b0;
    core_rs_out      = 1'b0;
    core_op_mode_out = MODE_DTW_READ;
    load_ack_out     = 1'b0;
    load_fail_out    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_req_in)    state_nxt = ST_LOAD;
        else if (enable_in) state_nxt = ST_SERVE;
      end
      ST_SERVE: begin
        core_rs_out = 1'b1;
        if (load_req_in || !enable_in) state_nxt = ST_DRAIN;
        else                           do_grant  = pick_any;
      end
      ST_DRAIN: begin
        core_rs_out = 1'b1;
        if (!pipe_busy) begin
          if (load_req_in)    state_nxt = ST_LOAD;
          else if (enable_in) state_nxt = ST_SERVE;
          else                state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        core_rs_out      = 1'b1;
        core_op_mode_out = MODE_LOAD_REF;
        if (load_ok || load_tmo) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        core_rs_out   = 1'b1;
        load_ack_out  = 1'b1;
        load_fail_out = fail_q;
        state_nxt     = enable_in ? ST_SERVE : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      addr_q    <= '0;
      tmo_cnt   <= '0;
      seen_busy <= 1'b0;
      fail_q    <= 1'b0;
      pipe_vld  <= '0;
      pipe_err  <= '0;
      // NOTE: the tag array is only RD_LATENCY entries, so it is reset like plain flops.
      for (int i = 0; i < RD_LATENCY; i++) pipe_id[i] <= '0;
    end else begin
      // NOTE: all state here uses <= so every register samples pre-edge values.
      state <= state_nxt;

      if (state != ST_LOAD) begin
        tmo_cnt   <= '0;
        seen_busy <= 1'b0;
      end else begin
        seen_busy <= seen_busy | core_busy_in;
        fail_q    <= load_tmo;
        if (!seen_busy && !core_busy_in) tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (do_grant) begin
        rr_ptr <= (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
        addr_q <= win_addr;
      end

      pipe_vld[0] <= do_grant;
      pipe_err[0] <= win_err;
      pipe_id[0]  <= pick_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_err[i] <= pipe_err[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  assign grant_out    = do_grant ? pick_onehot : '0;
  assign ref_addr_out = do_grant ? win_addr : addr_q;
  assign state_out    = state;

  always_comb begin
    rsp_valid_out = '0;
    rsp_data_out  = '0;
    rsp_err_out   = 1'b0;
    if (pipe_vld[LAST]) begin
      rsp_valid_out[pipe_id[LAST]] = 1'b1;
      rsp_err_out                  = pipe_err[LAST];
      if (!pipe_err[LAST]) rsp_data_out = ref_data_in;
    end
  end

endmodule

// File: tb/tb_dtw_ref_arbiter.sv
// Directed bench for dtw_ref_arbiter: grants checked in-cycle, responses checked by a scoreboard
// monitor against a two-register core memory model returning data[a] = a + 100.
module tb_dtw_ref_arbiter;
  import dtw_ref_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int PW = 20;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            enable_in;
  logic            load_req_in;
  logic [AW-1:0]   ref_len_in;
  logic [N-1:0]    req_valid_in;
  logic [N*PW-1:0] req_addr_in;
  logic [N-1:0]    grant_out;
  logic [N-1:0]    rsp_valid_out;
  logic [DW-1:0]   rsp_data_out;
  logic            rsp_err_out;
  logic            load_ack_out;
  logic            load_fail_out;
  logic            core_rs_out;
  logic            core_op_mode_out;
  logic            core_busy_in;
  logic [PW-1:0]   ref_addr_out;
  logic [DW-1:0]   ref_data_in;
  logic [2:0]      state_out;

  logic [PW-1:0]   addrs [N];
  logic [PW-1:0]   mem_a1;
  logic [DW-1:0]   mem_d;
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;
  exp_t sb [$];

  dtw_ref_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REFMEM_PTR_WIDTH(PW),
    .RD_LATENCY(2), .LOAD_TIMEOUT(16)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .enable_in        (enable_in),
    .load_req_in      (load_req_in),
    .ref_len_in       (ref_len_in),
    .req_valid_in     (req_valid_in),
    .req_addr_in      (req_addr_in),
    .grant_out        (grant_out),
    .rsp_valid_out    (rsp_valid_out),
    .rsp_data_out     (rsp_data_out),
    .rsp_err_out      (rsp_err_out),
    .load_ack_out     (load_ack_out),
    .load_fail_out    (load_fail_out),
    .core_rs_out      (core_rs_out),
    .core_op_mode_out (core_op_mode_out),
    .core_busy_in     (core_busy_in),
    .ref_addr_out     (ref_addr_out),
    .ref_data_in      (ref_data_in),
    .state_out        (state_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Core model: address register then memory register.
  always @(posedge clk_in) begin
    mem_a1 <= ref_addr_out;
    mem_d  <= DW'(mem_a1 + PW'(100));
  end
  assign ref_data_in = mem_d;

  always_comb begin
    req_addr_in = '0;
    for (int i = 0; i < N; i++) req_addr_in[i*PW +: PW] = addrs[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every valid response must match the oldest expected entry, on its cycle.
  always @(negedge clk_in) begin
    if (rsp_valid_out != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", rsp_valid_out, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_valid", rsp_valid_out, 64'(1) << e.id);
        check("rsp_data", rsp_data_out, e.data);
        check("rsp_err", rsp_err_out, e.err);
        check("rsp_cycle", cyc, e.cyc);
      end
    end else if (!rst_in) begin
      check("idle_rsp_zero", {rsp_err_out, rsp_data_out}, 0);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One request cycle: check the combinational grant, queue the expected response.
  task automatic step_grant(input logic [N-1:0] vld, input int win, input bit push,
                            input logic [DW-1:0] exp_data, input logic exp_err);
    exp_t e;
    req_valid_in = vld;
    @(negedge clk_in);
    if (win < 0) begin
      check("no_grant", grant_out, 0);
    end else begin
      check("grant", grant_out, 64'(1) << win);
      check("ref_addr", ref_addr_out, addrs[win]);
      if (push) begin
        e.id = win; e.data = exp_data; e.err = exp_err; e.cyc = cyc + 2;
        sb.push_back(e);
      end
    end
    tick();
  endtask

  task automatic idle(input int n);
    req_valid_in = '0;
    repeat (n) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk_in);
    check({tag, "_grant"}, grant_out, 0);
    check({tag, "_rsp_valid"}, rsp_valid_out, 0);
    check({tag, "_rsp_data"}, rsp_data_out, 0);
    check({tag, "_rsp_err"}, rsp_err_out, 0);
    check({tag, "_ack"}, {load_ack_out, load_fail_out}, 0);
    check({tag, "_core_rs"}, core_rs_out, 0);
    check({tag, "_op_mode"}, core_op_mode_out, 0);
    check({tag, "_ref_addr"}, ref_addr_out, 0);
    check({tag, "_state"}, state_out, ST_IDLE);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk_in);
      if (state_out == st) found = 1;
    end
    check(name, found, 1);
  endtask

  initial begin
    int acks, fail_seen, load_cycles;
    rst_in = 1'b1; enable_in = 1'b0; load_req_in = 1'b0; ref_len_in = 1000;
    req_valid_in = '0; core_busy_in = 1'b0;
    for (int i = 0; i < N; i++) addrs[i] = '0;

    repeat (3) tick();
    check_reset_outputs("reset");
    tick();
    rst_in = 1'b0; enable_in = 1'b1;
    tick();

    // Single requester 2, addr 5.
    addrs[2] = 5;
    step_grant(4'b0100, 2, 1, 105, 0);
    idle(4);

    // Fresh rr_ptr, all four requesting continuously.
    rst_in = 1'b1; tick(); tick(); rst_in = 1'b0; tick();
    addrs[0] = 11; addrs[1] = 22; addrs[2] = 33; addrs[3] = 44;
    step_grant(4'b1111, 0, 1, 111, 0);
    step_grant(4'b1111, 1, 1, 122, 0);
    step_grant(4'b1111, 2, 1, 133, 0);
    step_grant(4'b1111, 3, 1, 144, 0);
    step_grant(4'b1111, 0, 1, 111, 0);
    step_grant(4'b1111, 1, 1, 122, 0);
    idle(4);

    // Length boundary: 10 is out of range, 9 is the last valid sample.
    ref_len_in = 10;
    addrs[1] = 10;
    step_grant(4'b0010, 1, 1, 0, 1);
    addrs[1] = 9;
    step_grant(4'b0010, 1, 1, 109, 0);
    idle(3);
    ref_len_in = 1000;

    // Two grants, then a load request: drain, load with an 8-cycle busy core, resume.
    addrs[0] = 7; addrs[3] = 8;
    step_grant(4'b1001, 3, 1, 108, 0);
    step_grant(4'b0001, 0, 1, 107, 0);
    load_req_in = 1'b1;
    step_grant(4'b0010, -1, 0, 0, 0);
    step_grant(4'b0010, -1, 0, 0, 0);
    req_valid_in = '0;
    wait_state(ST_LOAD, 10, "reach_load");
    load_req_in = 1'b0;
    check("drained_before_load", sb.size(), 0);
    check("load_op_mode", core_op_mode_out, MODE_LOAD_REF);
    check("load_core_rs", core_rs_out, 1);
    tick();
    core_busy_in = 1'b1;
    repeat (8) tick();
    core_busy_in = 1'b0;
    acks = 0; fail_seen = 0;
    repeat (10) begin
      @(negedge clk_in);
      if (load_ack_out) begin
        acks++;
        fail_seen = int'(load_fail_out);
      end
    end
    check("load_ack_count", acks, 1);
    check("load_fail_busy", fail_seen, 0);
    check("resume_serve", state_out, ST_SERVE);
    tick();
    addrs[2] = 5;
    step_grant(4'b0100, 2, 1, 105, 0);
    idle(3);

    // Load with a core that never goes busy: 16 cycles in LOAD, then failing ack.
    load_req_in = 1'b1;
    wait_state(ST_LOAD, 10, "reach_load_tmo");
    load_req_in = 1'b0;
    load_cycles = 0; acks = 0; fail_seen = 0;
    for (int i = 0; i < 40 && acks == 0; i++) begin
      if (state_out == ST_LOAD) load_cycles++;
      if (load_ack_out) begin
        acks = 1;
        fail_seen = int'(load_fail_out);
      end
      if (acks == 0) @(negedge clk_in);
    end
    check("tmo_ack_seen", acks, 1);
    check("tmo_load_cycles", load_cycles, 16);
    check("tmo_fail_flag", fail_seen, 1);
    tick();
    tick();

    // Reset one cycle after a grant: the in-flight response must vanish.
    step_grant(4'b0100, 2, 0, 0, 0);
    req_valid_in = '0;
    rst_in = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst_in = 1'b0;
    repeat (4) begin
      @(negedge clk_in);
      check("post_reset_no_rsp", rsp_valid_out, 0);
    end

    idle(3);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
